// File: rtl/countdown_timer_pkg.sv
// Shared state encoding, field limits and setpoint clamping for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] v);
    return (v > HOUR_W'(HOUR_MAX)) ? HOUR_W'(HOUR_MAX) : v;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sixty(input logic [SEC_W-1:0] v);
    return (v > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : v;
  endfunction

endpackage

// File: rtl/countdown_timer_down_counter.sv
// Single time-field down counter; wraps to MAX and raises a same-cycle borrow when decremented at zero.
module down_counter #(
  parameter int MAX   = 9,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] o_val,
  output logic             o_borrow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] val_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_reg <= '0;
    end else if (clear) begin
      val_reg <= '0;
    end else if (load) begin
      val_reg <= load_val;
    end else if (i_dec) begin
      val_reg <= (val_reg == '0) ? MAX_V : val_reg - 1'b1;
    end
  end

  assign o_val    = val_reg;
  assign o_borrow = i_dec & (val_reg == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads hh:mm:ss, counts down in 100 Hz steps through a borrow chain,
// then holds an alarm for ALARM_TICKS ticks or until acknowledged.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int FCOUNT      = 1_000_000 - 1,
  parameter int ALARM_TICKS = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_runstop,
  input  logic              btn_clear,
  input  logic              set_load,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic [MSEC_W-1:0] tm_msec,
  output logic [SEC_W-1:0]  tm_sec,
  output logic [MIN_W-1:0]  tm_min,
  output logic [HOUR_W-1:0] tm_hour,
  output logic              running,
  output logic              done,
  output logic              alarm
);

  localparam int PW = (FCOUNT > 0) ? $clog2(FCOUNT + 1) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(FCOUNT);
  localparam logic [AW-1:0] ALARM_TC = AW'(ALARM_TICKS - 1);

  state_t          state_reg;
  logic [PW-1:0]   presc_reg;
  logic [AW-1:0]   alarm_cnt_reg;
  logic            done_reg;

  logic            tick;
  logic            dec_en;
  logic            load_en;
  logic            time_nonzero;
  logic            last_step;
  logic            msec_borrow;
  logic            sec_borrow;
  logic            min_borrow;
  logic            hour_borrow_unused;

  assign tick         = (presc_reg == PRESC_TC);
  assign time_nonzero = |{tm_hour, tm_min, tm_sec, tm_msec};
  assign last_step    = (tm_msec == MSEC_W'(1)) && (tm_sec == '0) && (tm_min == '0) && (tm_hour == '0);

  // A pause or clear in the tick cycle suppresses the step; zero is never decremented.
  assign dec_en  = (state_reg == ST_RUN) && tick && !btn_clear && !btn_runstop;
  assign load_en = set_load && !btn_clear && ((state_reg == ST_IDLE) || (state_reg == ST_PAUSE));

  down_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk      (clk),
    .rst      (rst),
    .i_dec    (dec_en),
    .load     (load_en),
    .load_val ('0),
    .clear    (btn_clear),
    .o_val    (tm_msec),
    .o_borrow (msec_borrow)
  );

  down_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .i_dec    (msec_borrow),
    .load     (load_en),
    .load_val (clamp_sixty(set_sec)),
    .clear    (btn_clear),
    .o_val    (tm_sec),
    .o_borrow (sec_borrow)
  );

  down_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk      (clk),
    .rst      (rst),
    .i_dec    (sec_borrow),
    .load     (load_en),
    .load_val (clamp_sixty(set_min)),
    .clear    (btn_clear),
    .o_val    (tm_min),
    .o_borrow (min_borrow)
  );

  down_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .i_dec    (min_borrow),
    .load     (load_en),
    .load_val (clamp_hour(set_hour)),
    .clear    (btn_clear),
    .o_val    (tm_hour),
    .o_borrow (hour_borrow_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      presc_reg     <= '0;
      alarm_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (btn_clear) begin
        state_reg     <= ST_IDLE;
        presc_reg     <= '0;
        alarm_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            presc_reg     <= '0;
            alarm_cnt_reg <= '0;
            if (!set_load && btn_runstop && time_nonzero) begin
              state_reg <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (btn_runstop) begin
              state_reg <= ST_PAUSE;
            end else begin
              presc_reg <= tick ? '0 : presc_reg + 1'b1;
              if (tick && last_step) begin
                state_reg     <= ST_ALARM;
                done_reg      <= 1'b1;
                alarm_cnt_reg <= '0;
              end
            end
          end
          ST_PAUSE: begin
            if (set_load) begin
              presc_reg <= '0;
            end else if (btn_runstop && time_nonzero) begin
              state_reg <= ST_RUN;
            end
          end
          ST_ALARM: begin
            if (btn_runstop) begin
              state_reg     <= ST_IDLE;
              alarm_cnt_reg <= '0;
              presc_reg     <= '0;
            end else begin
              presc_reg <= tick ? '0 : presc_reg + 1'b1;
              if (tick) begin
                if (alarm_cnt_reg == ALARM_TC) begin
                  state_reg     <= ST_IDLE;
                  alarm_cnt_reg <= '0;
                end else begin
                  alarm_cnt_reg <= alarm_cnt_reg + 1'b1;
                end
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign running = (state_reg == ST_RUN);
  assign alarm   = (state_reg == ST_ALARM);
  assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random button traffic against a
// reference model that tracks the remaining time as a single centisecond count.
module tb_countdown_timer;

  localparam int FC = 9;
  localparam int AT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_runstop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       set_load = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic [5:0] set_sec = '0;
  logic [6:0] tm_msec;
  logic [5:0] tm_sec;
  logic [5:0] tm_min;
  logic [4:0] tm_hour;
  logic       running;
  logic       done;
  logic       alarm;

  countdown_timer #(.FCOUNT(FC), .ALARM_TICKS(AT)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_runstop (btn_runstop),
    .btn_clear   (btn_clear),
    .set_load    (set_load),
    .set_hour    (set_hour),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .tm_msec     (tm_msec),
    .tm_sec      (tm_sec),
    .tm_min      (tm_min),
    .tm_hour     (tm_hour),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: remaining time is one integer of centiseconds.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_cs    = 0;
  int      m_pre   = 0;
  int      m_acnt  = 0;
  bit      m_done  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int setpoint_cs(input int h, input int m, input int s);
    int hh, mm, ss;
    hh = (h > 23) ? 23 : h;
    mm = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    return ((hh * 60 + mm) * 60 + ss) * 100;
  endfunction

  function automatic logic [31:0] hms(input int h, input int m, input int s, input int c);
    return 32'({5'(h), 6'(m), 6'(s), 7'(c)});
  endfunction

  function automatic logic [31:0] dut_time();
    return 32'({tm_hour, tm_min, tm_sec, tm_msec});
  endfunction

  function automatic logic [31:0] dut_pack();
    return 32'({tm_hour, tm_min, tm_sec, tm_msec, running, done, alarm});
  endfunction

  function automatic logic [31:0] model_pack();
    return 32'({5'(m_cs / 360000), 6'((m_cs / 6000) % 60), 6'((m_cs / 100) % 60), 7'(m_cs % 100),
                m_state == M_RUN, m_done, m_state == M_ALARM});
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_cs    = 0;
    m_pre   = 0;
    m_acnt  = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_update(input bit clr, input bit ld, input bit rs, input int h, input int m, input int s);
    bit tick;
    tick   = (m_pre == FC);
    m_done = 1'b0;
    if (clr) begin
      m_state = M_IDLE;
      m_cs    = 0;
      m_pre   = 0;
      m_acnt  = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          m_pre  = 0;
          m_acnt = 0;
          if (ld) m_cs = setpoint_cs(h, m, s);
          else if (rs && m_cs > 0) m_state = M_RUN;
        end
        M_RUN: begin
          if (rs) begin
            m_state = M_PAUSE;
          end else begin
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
              m_cs = m_cs - 1;
              if (m_cs == 0) begin
                m_state = M_ALARM;
                m_done  = 1'b1;
                m_acnt  = 0;
              end
            end
          end
        end
        M_PAUSE: begin
          if (ld) begin
            m_cs  = setpoint_cs(h, m, s);
            m_pre = 0;
          end else if (rs && m_cs > 0) begin
            m_state = M_RUN;
          end
        end
        M_ALARM: begin
          if (rs) begin
            m_state = M_IDLE;
            m_acnt  = 0;
            m_pre   = 0;
          end else begin
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
              m_acnt = m_acnt + 1;
              if (m_acnt == AT) begin
                m_state = M_IDLE;
                m_acnt  = 0;
              end
            end
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  // One clock of stimulus; outputs are compared with the model on the following falling edge.
  task automatic step(input bit clr, input bit ld, input bit rs, input int h, input int m, input int s);
    btn_clear   = clr;
    set_load    = ld;
    btn_runstop = rs;
    set_hour    = 5'(h);
    set_min     = 6'(m);
    set_sec     = 6'(s);
    if (clr || ld || rs)
      $display("[TB] cyc=%0d clear=%0b load=%0b runstop=%0b set=%0d:%0d:%0d", cyc, clr, ld, rs, h, m, s);
    @(posedge clk);
    model_update(clr, ld, rs, h, m, s);
    @(negedge clk);
    cyc++;
    btn_clear   = 1'b0;
    set_load    = 1'b0;
    btn_runstop = 1'b0;
    check_val("cycle", dut_pack(), model_pack());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_val("reset_state", dut_pack(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 1: one second to zero, done pulse, alarm timeout
    step(1'b0, 1'b1, 1'b0, 0, 0, 1);
    check_val("t1_load", dut_time(), hms(0, 0, 1, 0));
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    check_val("t1_running", 32'(running), 32'd1);
    idle(9);
    check_val("t1_before_tick", dut_time(), hms(0, 0, 1, 0));
    idle(1);
    check_val("t1_first_tick", dut_time(), hms(0, 0, 0, 99));
    idle(990);
    check_val("t1_zero", dut_time(), 32'd0);
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_alarm", 32'(alarm), 32'd1);
    idle(1);
    check_val("t1_done_once", 32'(done), 32'd0);
    check_val("t1_alarm_hold", 32'(alarm), 32'd1);
    idle(48);
    check_val("t1_alarm_late", 32'(alarm), 32'd1);
    idle(1);
    check_val("t1_alarm_end", 32'(alarm), 32'd0);
    check_val("t1_idle", 32'(running), 32'd0);

    // 2: full borrow chain in one step
    step(1'b0, 1'b1, 1'b0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(9);
    check_val("t2_hold", dut_time(), hms(1, 0, 0, 0));
    idle(1);
    check_val("t2_borrow", dut_time(), hms(0, 59, 59, 99));
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);

    // 3: pause freezes, resume lands after the prescaler residue
    step(1'b0, 1'b1, 1'b0, 0, 0, 5);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(33);
    check_val("t3_run3", dut_time(), hms(0, 0, 4, 97));
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(50);
    check_val("t3_frozen", dut_time(), hms(0, 0, 4, 97));
    check_val("t3_paused", 32'(running), 32'd0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(6);
    check_val("t3_resume_hold", dut_time(), hms(0, 0, 4, 97));
    idle(1);
    check_val("t3_resume_step", dut_time(), hms(0, 0, 4, 96));
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);

    // 4: clamping, start at zero ignored, load during RUN ignored
    step(1'b0, 1'b1, 1'b0, 0, 0, 63);
    check_val("t4_clamp_sec", dut_time(), hms(0, 0, 59, 0));
    step(1'b0, 1'b1, 1'b0, 31, 63, 63);
    check_val("t4_clamp_all", dut_time(), hms(23, 59, 59, 0));
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    check_val("t4_zero_start", 32'(running), 32'd0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 2);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1, 1, 1);
    check_val("t4_load_in_run", dut_time(), hms(0, 0, 2, 0));
    check_val("t4_still_run", 32'(running), 32'd1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);

    // 5: simultaneous buttons, clear on a tick
    step(1'b0, 1'b1, 1'b0, 0, 0, 3);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 0, 0, 9);
    check_val("t5_all_three", dut_pack(), 32'd0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 3);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(9);
    check_val("t5_pre_tick", dut_time(), hms(0, 0, 3, 0));
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    check_val("t5_clear_on_tick", dut_time(), 32'd0);

    // 6: asynchronous reset mid-run, acknowledge in ALARM
    step(1'b0, 1'b1, 1'b0, 0, 0, 3);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(15);
    #2 rst = 1'b1;
    #1 check_val("t6_async_rst", dut_pack(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(1000);
    check_val("t6_in_alarm", 32'(alarm), 32'd1);
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    check_val("t6_ack", dut_pack(), 32'd0);

    // Random button traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit clr, ld, rs;
      int h, m, s;
      clr = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 79) == 0);
      rs  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 0) begin
        h = 0;
        m = 0;
        s = int'($urandom_range(0, 2));
      end else begin
        h = int'($urandom_range(0, 31));
        m = int'($urandom_range(0, 63));
        s = int'($urandom_range(0, 63));
      end
      step(clr, ld, rs, h, m, s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
